// File: rtl/lr_row_collector.sv
// lr_row_collector: realigns skewed leaky-ReLU columns into whole rows and
//   writes them to the unified buffer at sequential addresses.
// Latency: last column of a row sampled at edge E -> ub_wr_valid high after E+1;
//   one row per cycle while ub_wr_ready stays high.
// Backpressure: ub_wr_ready stalls the output register; upstream is never
//   stalled, a push into a full column FIFO is dropped and sets overflow_err.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_*               pass configuration, latched on cfg_start in IDLE
//   lr_valid_in/data_in per-column input, column i in slice i
//   ub_wr_*             row write request, valid/ready handshake
//   busy, done          RUN indicator, one-cycle completion pulse
//   overflow_err        sticky column-FIFO overflow flag
module lr_row_collector #(
  parameter int N      = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [15:0]         cfg_num_rows,
  input  logic [N-1:0]        lr_valid_in,
  input  logic [N*16-1:0]     lr_data_in,
  input  logic                ub_wr_ready,
  output logic                ub_wr_valid,
  output logic [ADDR_W-1:0]   ub_wr_addr,
  output logic [N*16-1:0]     ub_wr_data,
  output logic                busy,
  output logic                done,
  output logic                overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state, state_nxt;
  logic [15:0]   num_rows;
  logic [15:0]   rows_written, rows_written_nxt;
  logic [15:0]   rows_popped;
  logic [15:0]   mem [N][DEPTH];
  logic [PW:0]   wr_ptr [N];
  logic [PW:0]   rd_ptr [N];
  logic [N-1:0]  empty, full, push_ok, push_drop;
  logic          pop, xfer, start;

  assign start = (state == IDLE) && cfg_start;
  assign xfer  = ub_wr_valid && ub_wr_ready;
  assign busy  = (state == RUN);
  assign done  = (state == FIN);
  assign rows_written_nxt = rows_written + {15'd0, xfer};

  // A row pops only when every column has data, the output register is free
  // (or emptying this cycle) and the programmed row count is not yet reached.
  assign pop = (state == RUN) && (&(~empty)) && (!ub_wr_valid || ub_wr_ready) &&
               (rows_popped != num_rows);

  always_comb begin
    empty     = '0;
    full      = '0;
    push_ok   = '0;
    push_drop = '0;
    for (int i = 0; i < N; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][PW-1:0] == rd_ptr[i][PW-1:0]) &&
                 (wr_ptr[i][PW] != rd_ptr[i][PW]);
      // A full FIFO that is popping this cycle frees its slot in time.
      push_ok[i]   = (state == RUN) && lr_valid_in[i] && (!full[i] || pop);
      push_drop[i] = (state == RUN) && lr_valid_in[i] && full[i] && !pop;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = RUN;
      RUN:     if (rows_written_nxt == num_rows) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage carries no reset; pointers define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push_ok[i]) mem[i][wr_ptr[i][PW-1:0]] <= lr_data_in[i*16 +: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      num_rows     <= '0;
      rows_written <= '0;
      rows_popped  <= '0;
      ub_wr_valid  <= 1'b0;
      ub_wr_addr   <= '0;
      ub_wr_data   <= '0;
      overflow_err <= 1'b0;
      for (int i = 0; i < N; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (|push_drop) overflow_err <= 1'b1;
      if (start) begin
        num_rows     <= cfg_num_rows;
        rows_written <= '0;
        rows_popped  <= '0;
        ub_wr_addr   <= cfg_base_addr;
        for (int i = 0; i < N; i++) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
          if (pop)        rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
        end
        if (pop) rows_popped <= rows_popped + 16'd1;
        if (xfer) begin
          rows_written <= rows_written_nxt;
          ub_wr_addr   <= ub_wr_addr + ADDR_W'(1);
        end
      end
      if (pop) begin
        ub_wr_valid <= 1'b1;
        for (int i = 0; i < N; i++) begin
          ub_wr_data[i*16 +: 16] <= mem[i][rd_ptr[i][PW-1:0]];
        end
      end else if (xfer) begin
        ub_wr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lr_row_collector.sv
// tb_lr_row_collector: randomized stimulus with a scoreboard of expected row
//   writes; a negedge monitor pops and compares every accepted write and
//   checks stall stability, done timing and unexpected writes.
module tb_lr_row_collector;

  localparam int N     = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_start;
  logic [AW-1:0]   cfg_base_addr;
  logic [15:0]     cfg_num_rows;
  logic [N-1:0]    lr_valid_in;
  logic [N*16-1:0] lr_data_in;
  logic            ub_wr_ready;
  logic            ub_wr_valid;
  logic [AW-1:0]   ub_wr_addr;
  logic [N*16-1:0] ub_wr_data;
  logic            busy;
  logic            done;
  logic            overflow_err;

  lr_row_collector #(.N(N), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_num_rows(cfg_num_rows), .lr_valid_in(lr_valid_in), .lr_data_in(lr_data_in),
    .ub_wr_ready(ub_wr_ready), .ub_wr_valid(ub_wr_valid), .ub_wr_addr(ub_wr_addr),
    .ub_wr_data(ub_wr_data), .busy(busy), .done(done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [N*16-1:0] data;
  } wr_t;

  int   errors = 0;
  int   checks = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  wr_t  stall_w;
  logic stall_prev = 1'b0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   start_cyc = -1;
  int   last_xfer_cyc = -1;
  int   valid_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 64'(ub_wr_valid), 64'd1);
        check("hold_row", 64'({ub_wr_addr, ub_wr_data}), 64'(stall_w));
      end
      if (ub_wr_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                   ub_wr_addr, ub_wr_data);
        end else if (ub_wr_ready) begin
          mon_e = exp_q.pop_front();
          check("write", 64'({ub_wr_addr, ub_wr_data}), 64'(mon_e));
          last_xfer_cyc = cyc;
        end
      end
      stall_prev = ub_wr_valid && !ub_wr_ready;
      stall_w    = {ub_wr_addr, ub_wr_data};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cfg_start && !busy && !done) start_cyc = cyc;
    end
  end

  // One pass: nstream rows streamed with column i skewed by i cycles, the
  // first nrows of them expected at base, base+1, ... (mod 2^AW).
  // rmode: 0 ready high, 1 random ready, 2 ready low for the first stall_len cycles.
  task automatic run_pass(input logic [AW-1:0] base, input int nrows, input int nstream,
                          input int gapmax, input int rmode, input int stall_len,
                          input logic exp_ovf);
    logic [15:0]     rd [8][N];
    int              st [8];
    bit              sv [N][64];
    logic [15:0]     sd [N][64];
    logic [N*16-1:0] rowv;
    logic [AW-1:0]   a;
    int              t = 0;
    int              len;
    for (int i = 0; i < N; i++)
      for (int c = 0; c < 64; c++) begin
        sv[i][c] = 1'b0;
        sd[i][c] = 16'h0;
      end
    for (int k = 0; k < nstream; k++) begin
      st[k] = t;
      for (int i = 0; i < N; i++) rd[k][i] = 16'($urandom);
      t += 1 + int'($urandom_range(0, gapmax));
    end
    len = t + N + 1;
    for (int k = 0; k < nstream; k++)
      for (int i = 0; i < N; i++) begin
        sv[i][st[k] + i] = 1'b1;
        sd[i][st[k] + i] = rd[k][i];
      end
    for (int k = 0; k < nrows && k < nstream; k++) begin
      for (int i = 0; i < N; i++) rowv[i*16 +: 16] = rd[k][i];
      a = base + AW'(k);
      exp_q.push_back({a, rowv});
    end
    @(posedge clk); #1;
    cfg_base_addr = base;
    cfg_num_rows  = 16'(nrows);
    cfg_start     = 1'b1;
    done_cnt      = 0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int c = 0; c < len; c++) begin
      for (int i = 0; i < N; i++) begin
        lr_valid_in[i]          = sv[i][c];
        lr_data_in[i*16 +: 16]  = sd[i][c];
      end
      if (rmode == 0)      ub_wr_ready = 1'b1;
      else if (rmode == 1) ub_wr_ready = ($urandom_range(0, 3) != 0);
      else                 ub_wr_ready = (c >= stall_len);
      @(posedge clk); #1;
    end
    lr_valid_in = '0;
    ub_wr_ready = 1'b1;
    for (int w = 0; w < 200 && done_cnt == 0; w++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("rows_left", 64'(exp_q.size()), 64'd0);
    check("overflow_err", 64'(overflow_err), 64'(exp_ovf));
    check("busy_after", 64'(busy), 64'd0);
    if (nrows == 0) check("done_after_start", 64'(done_cyc - start_cyc), 64'd2);
    else            check("done_after_xfer", 64'(done_cyc - last_xfer_cyc), 64'd1);
  endtask

  initial begin
    int nr;
    int v0;
    rst = 1'b1; cfg_start = 1'b0; cfg_base_addr = '0; cfg_num_rows = '0;
    lr_valid_in = '0; lr_data_in = '0; ub_wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(ub_wr_valid), 64'd0);
    check("rst_addr", 64'(ub_wr_addr), 64'd0);
    check("rst_data", 64'(ub_wr_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(overflow_err), 64'd0);
    rst = 1'b0;

    // Basic pass, ready high.
    run_pass(16'h0010, 3, 3, 0, 0, 0, 1'b0);
    // Output stalled for several cycles after the first row is presented.
    run_pass(16'h0010, 3, 3, 0, 2, 7, 1'b0);
    // Ready low throughout: output register plus DEPTH FIFO entries hold
    // DEPTH+1 rows, so a sixth streamed row overflows; five are programmed.
    run_pass(16'(16'h0200 + $urandom_range(0, 255)), 5, 6, 0, 2, 9, 1'b1);
    // Address wrap; overflow_err stays sticky across a new start.
    run_pass(16'hFFFF, 2, 2, 1, 0, 0, 1'b1);

    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("ovf_cleared", 64'(overflow_err), 64'd0);

    // Zero-row pass.
    run_pass(16'h1234, 0, 0, 0, 0, 0, 1'b0);

    // Valids while IDLE are dropped.
    v0 = valid_cnt;
    for (int c = 0; c < 6; c++) begin
      lr_valid_in = N'($urandom);
      lr_data_in  = (N*16)'({$urandom, $urandom});
      @(posedge clk); #1;
    end
    lr_valid_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_writes", 64'(valid_cnt - v0), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // Reset mid-pass while a row is presented.
    for (int k = 0; k < 3; k++) exp_q.push_back('0);
    @(posedge clk); #1;
    cfg_base_addr = 16'h0040; cfg_num_rows = 16'd3; cfg_start = 1'b1; ub_wr_ready = 1'b0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      lr_valid_in = {N'(c >= 1 && c <= 3)} << 1 | N'(c <= 2);
      lr_data_in  = (N*16)'($urandom);
      @(posedge clk); #1;
    end
    lr_valid_in = '0;
    for (int w = 0; w < 10 && !ub_wr_valid; w++) begin
      @(posedge clk); #1;
    end
    check("valid_before_rst", 64'(ub_wr_valid), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_outputs", 64'({ub_wr_valid, ub_wr_addr, ub_wr_data, busy, done, overflow_err}),
          64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    run_pass(16'h0050, 3, 3, 0, 0, 0, 1'b0);

    // Randomized passes; at most DEPTH+1 rows streamed so nothing overflows.
    for (int p = 0; p < 8; p++) begin
      nr = int'($urandom_range(1, DEPTH + 1));
      run_pass(16'($urandom), nr, nr + int'($urandom_range(0, DEPTH + 1 - nr)), 2, 1, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
